// File: rtl/cnn_pkg.sv
// Shared types and constants for the CIFAR-10 classifier pipeline.
package cnn_pkg;

  localparam int unsigned LOGIT_W         = 32;
  localparam int unsigned N_CLASSES_CIFAR = 10;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StWaitUp,
    StScan,
    StFinish,
    StDone
  } classifier_state_t;

endpackage

// File: rtl/top2_tracker.sv
// Running top-2 tracker over a stream of signed values; lower index wins ties in each rank.
module top2_tracker
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = LOGIT_W,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              init,
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] best,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] second,
  output logic [IDX_W-1:0]  second_idx
);

  localparam logic [DATA_W-1:0] MinVal   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  EmptyIdx = '1;

  logic [DATA_W-1:0] best_d, second_d;
  logic [IDX_W-1:0]  best_idx_d, second_idx_d;

  always_comb begin
    best_d       = best;
    best_idx_d   = best_idx;
    second_d     = second;
    second_idx_d = second_idx;
    if (en) begin
      if (init) begin
        best_d       = data;
        best_idx_d   = idx;
        second_d     = MinVal;
        second_idx_d = EmptyIdx;
      end else if ($signed(data) > $signed(best)) begin
        second_d     = best;
        second_idx_d = best_idx;
        best_d       = data;
        best_idx_d   = idx;
      end else if (($signed(data) > $signed(second)) || (second_idx == EmptyIdx)) begin
        // An empty runner-up slot takes any element, even one equal to the minimum.
        second_d     = data;
        second_idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      best       <= '0;
      best_idx   <= '0;
      second     <= '0;
      second_idx <= '0;
    end else begin
      best       <= best_d;
      best_idx   <= best_idx_d;
      second     <= second_d;
      second_idx <= second_idx_d;
    end
  end

endmodule

// File: rtl/argmax_top2_classifier.sv
// Final classifier stage: triggers the dense layer, scans its logits and holds the top-2 result.
module argmax_top2_classifier
  import cnn_pkg::*;
#(
  parameter int unsigned N_CLASSES = N_CLASSES_CIFAR,
  parameter int unsigned DATA_W    = LOGIT_W,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              up_start,
  input  logic              up_done,
  output logic [ADDR_W-1:0] logit_addr,
  input  logic [DATA_W-1:0] logit_data,
  output logic [ADDR_W-1:0] class_idx,
  output logic [DATA_W-1:0] max_logit,
  output logic [ADDR_W-1:0] second_idx,
  output logic [DATA_W-1:0] margin,
  output logic              busy,
  output logic              done
);

  localparam logic [DATA_W-1:0] MaxVal   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_CLASSES - 1);

  classifier_state_t state_q, state_d;
  logic              up_start_d, busy_d, done_d, load_result;
  logic [ADDR_W-1:0] addr_d;
  logic              trk_en, trk_init;

  logic [DATA_W-1:0] trk_best, trk_second;
  logic [ADDR_W-1:0] trk_best_idx, trk_second_idx;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] margin_d;

  top2_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (ADDR_W)
  ) u_tracker (
    .clk        (clk),
    .resetn     (resetn),
    .init       (trk_init),
    .en         (trk_en),
    .idx        (logit_addr),
    .data       (logit_data),
    .best       (trk_best),
    .best_idx   (trk_best_idx),
    .second     (trk_second),
    .second_idx (trk_second_idx)
  );

  always_comb begin
    state_d     = state_q;
    up_start_d  = 1'b0;
    done_d      = done;
    addr_d      = logit_addr;
    load_result = 1'b0;
    trk_en      = 1'b0;
    trk_init    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          up_start_d = 1'b1;
          done_d     = 1'b0;
          state_d    = StWaitUp;
        end
      end
      StWaitUp: begin
        if (up_done) begin
          addr_d  = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        trk_en   = 1'b1;
        trk_init = (logit_addr == '0);
        if (logit_addr == LastAddr) begin
          state_d = StFinish;
        end else begin
          addr_d = logit_addr + ADDR_W'(1);
        end
      end
      StFinish: begin
        load_result = 1'b1;
        done_d      = 1'b1;
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StWaitUp) || (state_d == StScan) || (state_d == StFinish);
  end

  // Best >= second, so the widened difference is never negative; only the top end saturates.
  always_comb begin
    diff     = {trk_best[DATA_W-1], trk_best} - {trk_second[DATA_W-1], trk_second};
    margin_d = diff[DATA_W-1:0];
    if (!diff[DATA_W] && diff[DATA_W-1]) begin
      margin_d = MaxVal;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      up_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      logit_addr <= '0;
      class_idx  <= '0;
      max_logit  <= '0;
      second_idx <= '0;
      margin     <= '0;
    end else begin
      state_q    <= state_d;
      up_start   <= up_start_d;
      busy       <= busy_d;
      done       <= done_d;
      logit_addr <= addr_d;
      if (load_result) begin
        class_idx  <= trk_best_idx;
        max_logit  <= trk_best;
        second_idx <= trk_second_idx;
        margin     <= margin_d;
      end
    end
  end

endmodule
